// File: rtl/merge_add_ctrl.sv
// Two-pick add sequencer and tile value bank for the tile-merge datapath.
// Optional selection timeout is built when SEL_TIMEOUT_EN is defined.
module merge_add_ctrl #(
    parameter int N       = 10,
    parameter int ADD_LAT = 1,
    parameter int TMO_W   = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             load,
    input  logic [N*4-1:0]   load_data,
    input  logic [N-1:0]     btn,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    input  logic [3:0]       add_sum,
    input  logic             add_cout,
    output logic [N*4-1:0]   values,
    output logic             sel_valid,
    output logic [3:0]       sel_idx,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        ADD  = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [1:0] LAT_LAST = 2'(ADD_LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] tile_q [N];
    logic [3:0] tile_d [N];
    logic [3:0] add_a_q, add_a_d;
    logic [3:0] add_b_q, add_b_d;
    logic [3:0] sel_idx_q, sel_idx_d;
    logic       sel_valid_q, sel_valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       ovf_q, ovf_d;
    logic [1:0] lat_cnt_q, lat_cnt_d;
`ifdef SEL_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    logic       pick_vld_s;
    logic [3:0] pick_idx_s;

    // Lowest-index pressed button wins; higher simultaneous presses are dropped.
    always_comb begin
        pick_idx_s = 4'd0;
        for (int i = N - 1; i >= 0; i--) begin
            pick_idx_s = btn[i] ? 4'(i) : pick_idx_s;
        end
        pick_vld_s = enable && (btn != {N{1'b0}});
    end

    // Next-state logic: load overrides everything, then the pick/add sequence.
    always_comb begin
        state_d     = state_q;
        tile_d      = tile_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        sel_idx_d   = sel_idx_q;
        sel_valid_d = sel_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ovf_d       = ovf_q;
        lat_cnt_d   = lat_cnt_q;
`ifdef SEL_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        if (load) begin
            for (int i = 0; i < N; i++) begin
                tile_d[i] = load_data[i*4 +: 4];
            end
            sel_valid_d = 1'b0;
            busy_d      = 1'b0;
            ovf_d       = 1'b0;
            state_d     = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld_s) begin
                        sel_idx_d   = pick_idx_s;
                        add_a_d     = tile_q[pick_idx_s];
                        sel_valid_d = 1'b1;
                        state_d     = SEL;
`ifdef SEL_TIMEOUT_EN
                        tmo_d       = {TMO_W{1'b0}};
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
                SEL: begin
                    if (pick_vld_s) begin
                        if (pick_idx_s == sel_idx_q) begin
                            sel_valid_d = 1'b0;
                            state_d     = IDLE;
                        end else begin
                            add_b_d   = tile_q[pick_idx_s];
                            busy_d    = 1'b1;
                            lat_cnt_d = 2'd0;
                            state_d   = ADD;
                        end
                    end else begin
`ifdef SEL_TIMEOUT_EN
                        // A stale selection is dropped exactly like a same-tile cancel.
                        if (tmo_q == {TMO_W{1'b1}}) begin
                            sel_valid_d = 1'b0;
                            state_d     = IDLE;
                        end else begin
                            tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
                        end
`else
                        state_d = SEL;
`endif
                    end
                end
                ADD: begin
                    if (lat_cnt_q == LAT_LAST) begin
                        state_d = WB;
                    end else begin
                        lat_cnt_d = lat_cnt_q + 2'd1;
                    end
                end
                WB: begin
                    tile_d[sel_idx_q] = add_sum;
                    ovf_d       = add_cout;
                    done_d      = 1'b1;
                    sel_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < N; i++) begin
                tile_q[i] <= 4'd0;
            end
            add_a_q     <= 4'd0;
            add_b_q     <= 4'd0;
            sel_idx_q   <= 4'd0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            lat_cnt_q   <= 2'd0;
`ifdef SEL_TIMEOUT_EN
            tmo_q       <= {TMO_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            for (int i = 0; i < N; i++) begin
                tile_q[i] <= tile_d[i];
            end
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            sel_idx_q   <= sel_idx_d;
            sel_valid_q <= sel_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            lat_cnt_q   <= lat_cnt_d;
`ifdef SEL_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign values[g*4 +: 4] = tile_q[g];
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign sel_idx   = sel_idx_q;
    assign sel_valid = sel_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_merge_add_ctrl.sv
// Self-checking bench for merge_add_ctrl: directed scenarios plus random
// presses/loads against a transaction-level model of the tile game.
module tb_merge_add_ctrl;

    localparam int N       = 10;
    localparam int ADD_LAT = 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             load = 1'b0;
    logic [N*4-1:0]   load_data = '0;
    logic [N-1:0]     btn = '0;
    logic [3:0]       add_a, add_b, add_sum, sel_idx;
    logic             add_cout, sel_valid, busy, done, ovf;
    logic [N*4-1:0]   values;
    logic [4:0]       sum_r;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_t [N];
    bit m_held;
    int m_idx, m_a, m_b, m_cnt;
    bit m_ovf, m_done;

    merge_add_ctrl #(.N(N), .ADD_LAT(ADD_LAT), .TMO_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
        .load_data(load_data), .btn(btn), .add_a(add_a), .add_b(add_b),
        .add_sum(add_sum), .add_cout(add_cout), .values(values),
        .sel_valid(sel_valid), .sel_idx(sel_idx), .busy(busy),
        .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // External registered adder, one cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_r <= 5'd0;
        else        sum_r <= {1'b0, add_a} + {1'b0, add_b};
    end
    assign add_sum  = sum_r[3:0];
    assign add_cout = sum_r[4];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_t[i] = 0;
        m_held = 0; m_idx = 0; m_a = 0; m_b = 0; m_cnt = 0; m_ovf = 0; m_done = 0;
    endtask

    task automatic model_step(input logic en, input logic ld,
                              input logic [N*4-1:0] ldd, input logic [N-1:0] b);
        int k;
        m_done = 0;
        k = -1;
        for (int i = 0; i < N; i++) if (b[i] && k < 0) k = i;
        if (ld) begin
            for (int i = 0; i < N; i++) m_t[i] = int'(ldd[i*4 +: 4]);
            m_held = 0; m_cnt = 0; m_ovf = 0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_t[m_idx] = (m_a + m_b) % 16;
                m_ovf  = (m_a + m_b) > 15;
                m_done = 1;
                m_held = 0;
            end
        end else if (en && k >= 0) begin
            if (!m_held) begin
                m_held = 1; m_idx = k; m_a = m_t[k];
            end else if (k == m_idx) begin
                m_held = 0;
            end else begin
                m_b = m_t[k];
                m_cnt = ADD_LAT + 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [N*4-1:0] ev;
        for (int i = 0; i < N; i++) ev[i*4 +: 4] = 4'(m_t[i]);
        check_eq({tag, ".values"},    64'(values),    64'(ev));
        check_eq({tag, ".sel_valid"}, 64'(sel_valid), 64'(m_held));
        check_eq({tag, ".sel_idx"},   64'(sel_idx),   64'(m_idx));
        check_eq({tag, ".add_a"},     64'(add_a),     64'(m_a));
        check_eq({tag, ".add_b"},     64'(add_b),     64'(m_b));
        check_eq({tag, ".busy"},      64'(busy),      64'(m_cnt > 0));
        check_eq({tag, ".done"},      64'(done),      64'(m_done));
        check_eq({tag, ".ovf"},       64'(ovf),       64'(m_ovf));
    endtask

    task automatic cycle(input logic en, input logic ld,
                         input logic [N*4-1:0] ldd, input logic [N-1:0] b);
        enable = en; load = ld; load_data = ldd; btn = b;
        @(posedge clk);
        model_step(en, ld, ldd, b);
        #1;
        check_all("cyc");
        load = 1'b0; btn = '0;
    endtask

    function automatic logic [N*4-1:0] pack4(input int v0, input int v1, input int v2, input int v3);
        logic [N*4-1:0] p;
        p = '0;
        p[3:0] = 4'(v0); p[7:4] = 4'(v1); p[11:8] = 4'(v2); p[15:12] = 4'(v3);
        return p;
    endfunction

    localparam logic [N*4-1:0] Z = '0;

    initial begin
        logic [63:0] r64;
        logic [N-1:0] rb;
        int r;
        model_reset();
        #2;
        check_all("reset");
        #1 rst_n = 1'b1;

        // Basic add 3+5
        cycle(1'b1, 1'b1, pack4(3, 5, 0, 0), '0);
        cycle(1'b1, 1'b0, Z, 10'b1);
        check_eq("t2.add_a", 64'(add_a), 64'd3);
        cycle(1'b1, 1'b0, Z, 10'b10);
        check_eq("t2.add_b", 64'(add_b), 64'd5);
        check_eq("t2.busy", 64'(busy), 64'd1);
        cycle(1'b1, 1'b0, Z, '0);
        cycle(1'b1, 1'b0, Z, '0);
        check_eq("t2.sum", 64'(values[3:0]), 64'd8);
        check_eq("t2.done", 64'(done), 64'd1);
        check_eq("t2.tileB", 64'(values[7:4]), 64'd5);
        cycle(1'b1, 1'b0, Z, '0);
        check_eq("t2.done_pulse", 64'(done), 64'd0);

        // Overflow 9+9 then 1+1 clears ovf
        cycle(1'b1, 1'b1, pack4(9, 9, 1, 1), '0);
        cycle(1'b1, 1'b0, Z, 10'b0001);
        cycle(1'b1, 1'b0, Z, 10'b0010);
        repeat (2) cycle(1'b1, 1'b0, Z, '0);
        check_eq("t3.wrap", 64'(values[3:0]), 64'd2);
        check_eq("t3.ovf1", 64'(ovf), 64'd1);
        cycle(1'b1, 1'b0, Z, 10'b0100);
        cycle(1'b1, 1'b0, Z, 10'b1000);
        repeat (2) cycle(1'b1, 1'b0, Z, '0);
        check_eq("t3.sum2", 64'(values[11:8]), 64'd2);
        check_eq("t3.ovf0", 64'(ovf), 64'd0);

        // Multi-press picks lowest; same tile cancels
        cycle(1'b1, 1'b1, pack4(4, 6, 7, 0), '0);
        cycle(1'b1, 1'b0, Z, 10'b0110);
        check_eq("t4.sel_idx", 64'(sel_idx), 64'd1);
        cycle(1'b1, 1'b0, Z, 10'b0010);
        check_eq("t4.cancel", 64'(sel_valid), 64'd0);
        cycle(1'b1, 1'b0, Z, '0);
        check_eq("t4.values", 64'(values), 64'(pack4(4, 6, 7, 0)));

        // Presses during ADD and with enable low; load aborts add
        cycle(1'b1, 1'b1, pack4(2, 3, 0, 0), '0);
        cycle(1'b1, 1'b0, Z, 10'b01);
        cycle(1'b1, 1'b0, Z, 10'b10);
        cycle(1'b1, 1'b0, Z, 10'b100);
        cycle(1'b1, 1'b0, Z, 10'b100);
        check_eq("t5.drop", 64'(values[3:0]), 64'd5);
        cycle(1'b0, 1'b0, Z, 10'b1);
        check_eq("t5.en_low", 64'(sel_valid), 64'd0);
        cycle(1'b1, 1'b0, Z, 10'b01);
        cycle(1'b1, 1'b0, Z, 10'b10);
        cycle(1'b1, 1'b1, pack4(1, 1, 0, 0), '0);
        repeat (3) begin
            cycle(1'b1, 1'b0, Z, '0);
            check_eq("t5.no_done", 64'(done), 64'd0);
        end
        check_eq("t5.reload", 64'(values), 64'(pack4(1, 1, 0, 0)));

        // Selection is held indefinitely without the timeout build
        cycle(1'b1, 1'b0, Z, 10'b100);
        repeat (20) cycle(1'b1, 1'b0, Z, '0);
        check_eq("t6.held", 64'(sel_valid), 64'd1);
        cycle(1'b1, 1'b0, Z, 10'b100);

        // Asynchronous reset in the middle of an add
        cycle(1'b1, 1'b1, pack4(5, 5, 0, 0), '0);
        cycle(1'b1, 1'b0, Z, 10'b01);
        cycle(1'b1, 1'b0, Z, 10'b10);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        check_eq("t1.busy", 64'(busy), 64'd0);
        #1 rst_n = 1'b1;
        cycle(1'b1, 1'b0, Z, '0);
        cycle(1'b1, 1'b0, Z, 10'b1000);
        check_eq("t1.idle_pick", 64'(sel_valid), 64'd1);

        // Random play
        for (int c = 0; c < 3000; c++) begin
            r64 = {$urandom(), $urandom()};
            r = $urandom_range(0, 9);
            rb = N'($urandom());
            if (r < 5)      rb = '0;
            else if (r < 8) rb = N'(1) << $urandom_range(0, N - 1);
            cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0), r64[N*4-1:0], rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
